// File: rtl/piano_note_scheduler_if.sv
// Handshake bundle between the piano note scheduler and its driver.
//   button      raw piano buttons, bit0 = note 1
//   play_start  one-cycle pulse, start melody playback
//   play_stop   one-cycle pulse, abort playback
//   tone_period half-period select for the tone generator
//   tone_on     tone generator enable
//   note_idx    current note 0..5 (0 = rest)
//   busy        high while the melody is playing
interface piano_note_scheduler_if #(
    parameter int PERIOD_W = 20
);
    logic [4:0]          button;
    logic                play_start;
    logic                play_stop;
    logic [PERIOD_W-1:0] tone_period;
    logic                tone_on;
    logic [2:0]          note_idx;
    logic                busy;

    modport master (
        output button, play_start, play_stop,
        input  tone_period, tone_on, note_idx, busy
    );

    modport slave (
        input  button, play_start, play_stop,
        output tone_period, tone_on, note_idx, busy
    );
endinterface

// File: rtl/piano_note_scheduler.sv
// Picks the note the buzzer tone generator plays.
// Live mode: synchronised, debounced buttons with a last-pressed-wins arbiter.
// Playback mode: steps a fixed 16-entry melody ROM at TEMPO_CYCLES per duration
// unit, with GAP_CYCLES of silence after every entry.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of piano_note_scheduler_if (buttons, play controls in;
//          registered tone_period / tone_on / note_idx / busy out)
module piano_note_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TEMPO_CYCLES    = 12500000,
    parameter int GAP_CYCLES      = 1000000,
    parameter int PERIOD_W        = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    piano_note_scheduler_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {LIVE, NOTE, GAP} state_t;

    // Melody ROM, note field. Entries past the end marker are rests.
    function automatic logic [2:0] mel_note(input logic [3:0] a);
        mel_note = 3'd0;
        case (a)
            4'd0:  mel_note = 3'd1;
            4'd1:  mel_note = 3'd2;
            4'd2:  mel_note = 3'd3;
            4'd3:  mel_note = 3'd4;
            4'd4:  mel_note = 3'd5;
            4'd6:  mel_note = 3'd5;
            4'd7:  mel_note = 3'd4;
            4'd8:  mel_note = 3'd3;
            4'd9:  mel_note = 3'd2;
            4'd10: mel_note = 3'd1;
            default: mel_note = 3'd0;
        endcase
    endfunction

    // Melody ROM, duration field in tempo units; 0 ends the melody.
    function automatic logic [2:0] mel_dur(input logic [3:0] a);
        mel_dur = 3'd0;
        case (a)
            4'd4, 4'd10: mel_dur = 3'd4;
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5,
            4'd6, 4'd7, 4'd8, 4'd9: mel_dur = 3'd2;
            default: mel_dur = 3'd0;
        endcase
    endfunction

    function automatic logic [PERIOD_W-1:0] period_of(input logic [2:0] n);
        period_of = '0;
        case (n)
            3'd1: period_of = PERIOD_W'(500000);
            3'd2: period_of = PERIOD_W'(200000);
            3'd3: period_of = PERIOD_W'(100000);
            3'd4: period_of = PERIOD_W'(40000);
            3'd5: period_of = PERIOD_W'(20000);
            default: period_of = '0;
        endcase
    endfunction

    // 1-based index of the lowest set bit, 0 when none.
    function automatic logic [2:0] lowest(input logic [4:0] v);
        lowest = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (v[i]) lowest = 3'(i + 1);
    endfunction

    // Audible part of an entry; the rest of its duration is the gap.
    function automatic logic [31:0] note_len(input logic [2:0] dur);
        note_len = 32'(dur) * 32'(TEMPO_CYCLES) - 32'(GAP_CYCLES);
    endfunction

    logic [4:0]           sync1, sync2, db, db_q, rise;
    logic [4:0][DB_W-1:0] db_cnt;
    state_t               state, state_n;
    logic [3:0]           ptr, ptr_n;
    logic [31:0]          cnt, cnt_n;
    logic [2:0]           sel, sel_n, note_n;
    logic                 abort;
    logic [2:0]           note_q;
    logic [PERIOD_W-1:0]  period_q;
    logic                 on_q, busy_q;

    // Two-flop synchroniser, then a per-button stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_q   <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= bus.button;
            sync2 <= sync1;
            db_q  <= db;
            for (int b = 0; b < 5; b++) begin
                if (sync2[b] == db[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[b] <= '0;
                    db[b]     <= ~db[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    assign rise  = db & ~db_q;
    assign abort = bus.play_stop || (rise != 5'd0);

    // The live selection tracks the buttons in every state so an abort by
    // key press lands on the pressed note in the same cycle.
    always_comb begin
        sel_n = sel;
        if (rise != 5'd0)
            sel_n = lowest(rise);
        else if (sel != 3'd0 && !db[sel - 3'd1])
            sel_n = lowest(db);
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            LIVE: begin
                if (bus.play_start && !bus.play_stop) begin
                    state_n = NOTE;
                    ptr_n   = 4'd0;
                    cnt_n   = '0;
                end
            end
            NOTE: begin
                if (abort) begin
                    state_n = LIVE;
                    cnt_n   = '0;
                end else if (cnt == note_len(mel_dur(ptr)) - 32'd1) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = LIVE;
                    cnt_n   = '0;
                end else if (cnt == 32'(GAP_CYCLES) - 32'd1) begin
                    cnt_n = '0;
                    ptr_n = ptr + 4'd1;
                    // ptr == 15 means the increment wraps: melody over.
                    if (ptr == 4'd15 || mel_dur(ptr + 4'd1) == 3'd0)
                        state_n = LIVE;
                    else
                        state_n = NOTE;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: begin
                state_n = LIVE;
                cnt_n   = '0;
            end
        endcase

        case (state_n)
            NOTE:    note_n = mel_note(ptr_n);
            LIVE:    note_n = sel_n;
            default: note_n = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LIVE;
            ptr      <= '0;
            cnt      <= '0;
            sel      <= '0;
            note_q   <= '0;
            period_q <= '0;
            on_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            sel      <= sel_n;
            note_q   <= note_n;
            period_q <= period_of(note_n);
            on_q     <= (note_n != 3'd0);
            busy_q   <= (state_n != LIVE);
        end
    end

    assign bus.note_idx    = note_q;
    assign bus.tone_period = period_q;
    assign bus.tone_on     = on_q;
    assign bus.busy        = busy_q;

endmodule
